// File: rtl/mod4591_fold_reduce.sv
// Folds six 12-bit LUT partial terms into one residue mod 4591. The pipeline is 3 registered stages with valid/ready; all stages stall together.
// MOD4591_UNSIGNED_OUT_EN selects a residue in [0, 4590]. Without it the residue is centered in [-2295, 2295].
module mod4591_fold_reduce #(
   parameter int Q     = 4591,
   parameter int W_IN  = 12,
   parameter int W_OUT = 13
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W_IN-1:0]  p0,
   input  logic [W_IN-1:0]  p1,
   input  logic [W_IN-1:0]  p2,
   input  logic [W_IN-1:0]  n0,
   input  logic [W_IN-1:0]  n1,
   input  logic [W_IN-1:0]  n2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W_OUT-1:0] r
);

   localparam int W_SUM = W_IN + 2;
   localparam int W_D   = W_IN + 3;

   localparam logic signed [W_D-1:0] ZERO = '0;
   localparam logic signed [W_D-1:0] Q1   = W_D'(Q);
   localparam logic signed [W_D-1:0] Q2   = W_D'(2 * Q);
   localparam logic signed [W_D-1:0] Q3   = W_D'(3 * Q);
   localparam logic signed [W_D-1:0] T1   = W_D'((Q - 1) / 2);
   localparam logic signed [W_D-1:0] T2   = W_D'((Q - 1) / 2 + Q);
   localparam logic signed [W_D-1:0] T3   = W_D'((Q - 1) / 2 + 2 * Q);

   logic                    advance;

   logic                    v1_q, v1_d;
   logic [W_SUM-1:0]        p_sum_q, p_sum_d;
   logic [W_SUM-1:0]        n_sum_q, n_sum_d;

   logic                    v2_q, v2_d;
   logic signed [W_D-1:0]   d_q, d_d;

   logic                    v3_q, v3_d;
   logic [W_OUT-1:0]        r_q, r_d;

   logic signed [W_D-1:0]   corr;

   assign advance   = !v3_q || out_ready;
   assign in_ready  = advance && !rst;
   assign out_valid = v3_q;
   assign r         = r_q;

   // corr = k*Q, where k picks the multiple of Q that moves D into the output range.
   always_comb begin
      corr = ZERO;
`ifdef MOD4591_UNSIGNED_OUT_EN
      if (d_q >= Q2)         corr = Q2;
      else if (d_q >= Q1)    corr = Q1;
      else if (d_q >= ZERO)  corr = ZERO;
      else if (d_q >= -Q1)   corr = -Q1;
      else if (d_q >= -Q2)   corr = -Q2;
      else                   corr = -Q3;
`else
      if (d_q > T3)          corr = Q3;
      else if (d_q > T2)     corr = Q2;
      else if (d_q > T1)     corr = Q1;
      else if (d_q < -T3)    corr = -Q3;
      else if (d_q < -T2)    corr = -Q2;
      else if (d_q < -T1)    corr = -Q1;
      else                   corr = ZERO;
`endif
   end

   always_comb begin
      v1_d    = v1_q;
      p_sum_d = p_sum_q;
      n_sum_d = n_sum_q;
      v2_d    = v2_q;
      d_d     = d_q;
      v3_d    = v3_q;
      r_d     = r_q;
      if (advance) begin
         v1_d    = in_valid;
         p_sum_d = W_SUM'(p0) + W_SUM'(p1) + W_SUM'(p2);
         n_sum_d = W_SUM'(n0) + W_SUM'(n1) + W_SUM'(n2);
         v2_d    = v1_q;
         d_d     = $signed({1'b0, p_sum_q}) - $signed({1'b0, n_sum_q});
         v3_d    = v2_q;
         r_d     = W_OUT'(d_q - corr);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q    <= 1'b0;
         p_sum_q <= '0;
         n_sum_q <= '0;
         v2_q    <= 1'b0;
         d_q     <= '0;
         v3_q    <= 1'b0;
         r_q     <= '0;
      end else begin
         v1_q    <= v1_d;
         p_sum_q <= p_sum_d;
         n_sum_q <= n_sum_d;
         v2_q    <= v2_d;
         d_q     <= d_d;
         v3_q    <= v3_d;
         r_q     <= r_d;
      end
   end

endmodule

// File: tb/tb_mod4591_fold_reduce.sv
// Directed bench for mod4591_fold_reduce: fixed vectors, latency, backpressure and reset flush.
module tb_mod4591_fold_reduce;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] p0, p1, p2, n0, n1, n2;
   logic        out_valid;
   logic        out_ready;
   logic [12:0] r;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef MOD4591_UNSIGNED_OUT_EN
   localparam logic [12:0] E_P4095 = 13'd4095;
   localparam logic [12:0] E_ALLP  = 13'd3103;
   localparam logic [12:0] E_ALLN  = 13'd1488;
   localparam logic [12:0] E_P2295 = 13'd2295;
   localparam logic [12:0] E_P2296 = 13'd2296;
   localparam logic [12:0] E_N2296 = 13'd2295;
   localparam logic [12:0] E_MIX   = 13'd809;
   localparam logic [12:0] E_NEG   = 13'd1002;
   localparam logic [12:0] E_M100  = 13'd4491;
`else
   localparam logic [12:0] E_P4095 = 13'h1E10;
   localparam logic [12:0] E_ALLP  = 13'h1A30;
   localparam logic [12:0] E_ALLN  = 13'd1488;
   localparam logic [12:0] E_P2295 = 13'd2295;
   localparam logic [12:0] E_P2296 = 13'h1709;
   localparam logic [12:0] E_N2296 = 13'd2295;
   localparam logic [12:0] E_MIX   = 13'd809;
   localparam logic [12:0] E_NEG   = 13'd1002;
   localparam logic [12:0] E_M100  = 13'h1F9C;
`endif

   mod4591_fold_reduce dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .p0        (p0),
      .p1        (p1),
      .p2        (p2),
      .n0        (n0),
      .n1        (n1),
      .n2        (n2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .r         (r)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_terms(input logic [11:0] a0, input logic [11:0] a1, input logic [11:0] a2,
                            input logic [11:0] b0, input logic [11:0] b1, input logic [11:0] b2);
      p0 = a0; p1 = a1; p2 = a2;
      n0 = b0; n1 = b1; n2 = b2;
   endtask

   // One isolated item: accepted now, silent for two cycles, valid on the third.
   task automatic run_one(input string tag,
                          input logic [11:0] a0, input logic [11:0] a1, input logic [11:0] a2,
                          input logic [11:0] b0, input logic [11:0] b1, input logic [11:0] b2,
                          input logic [12:0] exp);
      set_terms(a0, a1, a2, b0, b1, b2);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      check({tag, "_in_ready"}, int'(in_ready), 1);
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      set_terms(12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0);
      check({tag, "_lat1"}, int'(out_valid), 0);
      @(posedge clk); @(negedge clk);
      check({tag, "_lat2"}, int'(out_valid), 0);
      @(posedge clk); @(negedge clk);
      check({tag, "_vld"}, int'(out_valid), 1);
      check({tag, "_r"}, int'(r), int'(exp));
      @(posedge clk); @(negedge clk);
      check({tag, "_single"}, int'(out_valid), 0);
   endtask

   logic [11:0] vals [5];
   logic [12:0] outs [5];
   int          idx;
   int          got;
   logic        acc;

   initial begin
      vals[0] = 12'd100; vals[1] = 12'd200; vals[2] = 12'd300; vals[3] = 12'd400; vals[4] = 12'd500;
      rst       = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      set_terms(12'd7, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_r", int'(r), 0);
      rst      = 1'b0;
      in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      check("idle_out_valid", int'(out_valid), 0);

      run_one("zero",  12'd0,    12'd0,    12'd0,    12'd0,    12'd0,    12'd0,    13'd0);
      run_one("p4095", 12'd4095, 12'd0,    12'd0,    12'd0,    12'd0,    12'd0,    E_P4095);
      run_one("allp",  12'd4095, 12'd4095, 12'd4095, 12'd0,    12'd0,    12'd0,    E_ALLP);
      run_one("alln",  12'd0,    12'd0,    12'd0,    12'd4095, 12'd4095, 12'd4095, E_ALLN);
      run_one("p2295", 12'd2295, 12'd0,    12'd0,    12'd0,    12'd0,    12'd0,    E_P2295);
      run_one("p2296", 12'd2296, 12'd0,    12'd0,    12'd0,    12'd0,    12'd0,    E_P2296);
      run_one("n2296", 12'd0,    12'd0,    12'd0,    12'd2296, 12'd0,    12'd0,    E_N2296);
      run_one("mix",   12'd1000, 12'd2000, 12'd3000, 12'd100,  12'd200,  12'd300,  E_MIX);
      run_one("neg",   12'd10,   12'd0,    12'd0,    12'd4095, 12'd4095, 12'd0,    E_NEG);
      run_one("m100",  12'd0,    12'd0,    12'd0,    12'd100,  12'd0,    12'd0,    E_M100);

      // Fill with the output stalled: exactly three items fit.
      out_ready = 1'b0;
      idx       = 0;
      in_valid  = 1'b1;
      set_terms(vals[0], 12'd0, 12'd0, 12'd0, 12'd0, 12'd0);
      for (int c = 0; c < 6; c++) begin
         #1;
         acc = in_valid && in_ready;
         @(posedge clk); @(negedge clk);
         if (acc) idx++;
         if (idx < 5) p0 = vals[idx];
      end
      check("bp_accepted", idx, 3);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_r", int'(r), int'(vals[0]));
      @(posedge clk); @(negedge clk);
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_hold_r", int'(r), int'(vals[0]));

      // Drain and feed the remaining two.
      out_ready = 1'b1;
      got       = 0;
      for (int c = 0; c < 20 && got < 5; c++) begin
         #1;
         if (out_valid) begin
            outs[got] = r;
            got++;
         end
         acc = in_valid && in_ready;
         @(posedge clk); @(negedge clk);
         if (acc) idx++;
         if (idx < 5) p0 = vals[idx];
         else in_valid = 1'b0;
      end
      in_valid = 1'b0;
      check("drain_count", got, 5);
      check("drain_accepted", idx, 5);
      for (int i = 0; i < 5; i++) check($sformatf("drain_r%0d", i), int'(outs[i]), int'(vals[i]));
      @(posedge clk); @(negedge clk);
      check("drain_no_dup", int'(out_valid), 0);

      // Three items in flight, then a one-cycle reset.
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         p0 = vals[i];
         @(posedge clk); @(negedge clk);
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk); @(negedge clk);
      check("flush_out_valid", int'(out_valid), 0);
      check("flush_r", int'(r), 0);
      check("flush_in_ready", int'(in_ready), 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); @(negedge clk);
         check($sformatf("flush_quiet%0d", i), int'(out_valid), 0);
      end
      run_one("post_rst", 12'd4095, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, E_P4095);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
